// File: rtl/param_tff_updown_counter.sv
// Modulo-N up/down counter built on a bank of T flip-flops.
// Adds enable, synchronous load with clamp, wrap/saturate mode and a wrap pulse.
module param_tff_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int WRAP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             x,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] current_state,
    output logic [WIDTH-1:0] next_state,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam logic             WRAP_EN = (WRAP != 0);

    logic             at_max;
    logic             at_min;
    logic             wrap_d;
    logic [WIDTH-1:0] t;

    assign at_max = (current_state == MAX_VAL);
    assign at_min = (current_state == '0);
    assign tc     = x ? at_max : at_min;
    assign wrap_d = en & ~load & tc & WRAP_EN;
    assign t      = current_state ^ next_state;

    // Load beats enable; out-of-range loads clamp to the top of the range.
    always_comb begin
        next_state = current_state;
        if (load) begin
            if ({1'b0, load_val} < MOD_EXT)
                next_state = load_val;
            else
                next_state = MAX_VAL;
        end else if (en) begin
            if (x) begin
                if (!at_max)
                    next_state = current_state + WIDTH'(1);
                else if (WRAP_EN)
                    next_state = '0;
            end else begin
                if (!at_min)
                    next_state = current_state - WIDTH'(1);
                else if (WRAP_EN)
                    next_state = MAX_VAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state <= RST_VAL;
            wrap          <= 1'b0;
        end else begin
            current_state <= current_state ^ t;
            wrap          <= wrap_d;
        end
    end

endmodule

// File: tb/tb_param_tff_updown_counter.sv
// Scoreboard bench: wrap build (a) and saturate/RESET_VAL=3 build (b)
// share stimulus and are checked against an arithmetic reference model.
module tb_param_tff_updown_counter;

    localparam int M = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] cs_a, ns_a, cs_b, ns_b;
    logic       tc_a, wr_a, tc_b, wr_b;

    always #5 clk = ~clk;

    param_tff_updown_counter #(
        .WIDTH(4), .MODULUS(M), .WRAP(1), .RESET_VAL(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x),
        .load(load), .load_val(load_val),
        .current_state(cs_a), .next_state(ns_a),
        .tc(tc_a), .wrap(wr_a)
    );

    param_tff_updown_counter #(
        .WIDTH(4), .MODULUS(M), .WRAP(0), .RESET_VAL(3)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x),
        .load(load), .load_val(load_val),
        .current_state(cs_b), .next_state(ns_b),
        .tc(tc_b), .wrap(wr_b)
    );

    typedef struct {
        int cs_a; int ns_a; bit tc_a; bit wr_a;
        int cs_b; int ns_b; bit tc_b; bit wr_b;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;

    // Reference model state
    int ma = 0, mb = 3;
    bit mwa = 0, mwb = 0;
    int na = 0, nb = 3;
    bit wa = 0, wb = 0;
    bit rst_prev = 0;

    function automatic int mnext(int cs, bit e, bit d, bit ld, int lv, bit wm);
        if (ld) return (lv < M) ? lv : M - 1;
        if (!e) return cs;
        if (d) return wm ? (cs + 1) % M : ((cs + 1 > M - 1) ? M - 1 : cs + 1);
        return wm ? (cs + M - 1) % M : ((cs == 0) ? 0 : cs - 1);
    endfunction

    function automatic bit mtc(int cs, bit d);
        return d ? (cs == M - 1) : (cs == 0);
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d expected=%0d t=%0t",
                      name, act, exp, $time);
    endtask

    task automatic step(bit r, bit e, bit d, bit ld, int lv);
        exp_t ex;
        @(posedge clk);
        if (rst_prev) begin
            ma = na; mb = nb; mwa = wa; mwb = wb;
        end else begin
            ma = 0; mb = 3; mwa = 0; mwb = 0;
        end
        #1;
        rst_n = r; en = e; x = d; load = ld; load_val = 4'(lv);
        rst_prev = r;
        if (!r) begin
            ma = 0; mb = 3; mwa = 0; mwb = 0;
        end
        na = mnext(ma, e, d, ld, lv, 1'b1);
        nb = mnext(mb, e, d, ld, lv, 1'b0);
        wa = e && !ld && mtc(ma, d);
        wb = 1'b0;
        ex.cs_a = ma; ex.ns_a = na; ex.tc_a = mtc(ma, d); ex.wr_a = mwa;
        ex.cs_b = mb; ex.ns_b = nb; ex.tc_b = mtc(mb, d); ex.wr_b = mwb;
        q.push_back(ex);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("cs_a", int'(cs_a), e.cs_a);
            chk("ns_a", int'(ns_a), e.ns_a);
            chk("tc_a", int'(tc_a), int'(e.tc_a));
            chk("wrap_a", int'(wr_a), int'(e.wr_a));
            chk("cs_b", int'(cs_b), e.cs_b);
            chk("ns_b", int'(ns_b), e.ns_b);
            chk("tc_b", int'(tc_b), int'(e.tc_b));
            chk("wrap_b", int'(wr_b), int'(e.wr_b));
        end
    end

    initial begin
        int budget;
        // Reset, then up-count through the 9->0 wrap
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);
        // Load 2 and count down through 0->9
        step(1, 0, 0, 1, 2);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        // Load priority and clamp
        step(1, 1, 1, 1, 13);
        step(1, 1, 1, 1, 5);
        step(1, 0, 0, 1, 5);
        step(1, 0, 0, 0, 0);
        // Saturation from 7 upward, then from 1 downward
        step(1, 0, 1, 1, 7);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        // Hold at 4, then alternate direction
        step(1, 0, 1, 1, 4);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, (i % 2) == 0, 0, 0);
        // Async reset while counting at 6
        step(1, 0, 1, 1, 6);
        step(1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        // Back-to-back wraps by flipping direction at the ends
        step(1, 0, 1, 1, 9);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 15)));
        end
        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        #1;
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain pending=%0d expected=0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/param_tff_updown_counter.md
Name: param_tff_updown_counter

Overview:
- Parametrised modulo-N up/down counter; successor to the team's 2-bit x-controlled state-diagram counter.
- State held in a bank of WIDTH T flip-flops. Each toggle vector is derived as current XOR next, so every bit toggles only when its value changes.
- Adds enable, synchronous load, wrap-or-saturate mode, terminal-count flag and a registered wrap pulse.
- Used as a generic sequence/step counter in lab datapaths.

Parameters:
- WIDTH, 4, state width in bits (1..16).
- MODULUS, 10, count range 0..MODULUS-1; legal values 2..2^WIDTH.
- WRAP, 1: 1 = wrap at the ends of the range, 0 = saturate at the ends.
- RESET_VAL, 0, state after reset; must be < MODULUS.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, count enable.
- x, input, 1, direction: 1 = up, 0 = down.
- load, input, 1, synchronous load strobe.
- load_val, input, WIDTH, value to load.
- current_state, output, WIDTH, registered count.
- next_state, output, WIDTH, combinational value current_state will take at the next clk edge.
- tc, output, 1, combinational terminal-count flag.
- wrap, output, 1, registered one-cycle wrap pulse.

Behaviour:
- Reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
  - rst_n=0 immediately forces current_state=RESET_VAL and wrap=0, independent of clk.
  - Release is sampled at clk; the first count happens at the first rising edge with rst_n=1.
- State update: t = current_state ^ next_state; at each rising edge, current_state <= current_state ^ t.
- next_state priority, evaluated every cycle:
  1. load=1: next_state = load_val if load_val < MODULUS, else MODULUS-1 (clamp). Applies regardless of en and x.
  2. en=0: next_state = current_state (hold; t=0).
  3. en=1, x=1:
     - current_state < MODULUS-1: current_state+1.
     - current_state = MODULUS-1: 0 if WRAP=1; hold if WRAP=0.
  4. en=1, x=0:
     - current_state > 0: current_state-1.
     - current_state = 0: MODULUS-1 if WRAP=1; hold if WRAP=0.
- tc (combinational, independent of en and load):
  - x=1: tc=1 when current_state = MODULUS-1.
  - x=0: tc=1 when current_state = 0.
  - Otherwise tc=0.
- wrap:
  - Registered; equals 1 for exactly the cycle after an edge at which en=1, load=0, WRAP=1 and tc=1.
  - Equals 0 otherwise, including after loads and after saturation holds.
  - Back-to-back wraps (possible with MODULUS=2 or direction flips) give wrap high on consecutive cycles.
- Direction change: x may change any cycle. It takes effect on the next edge with no extra latency. tc follows x combinationally.
- Arithmetic:
  - WIDTH-bit, unsigned.
  - current_state never leaves 0..MODULUS-1 except transiently during reset assertion (RESET_VAL < MODULUS is guaranteed).
  - When MODULUS = 2^WIDTH, wrap arithmetic equals natural overflow.
- Reset mid-operation: an asserted rst_n overrides load/en on the same edge and clears any pending wrap pulse.
- Latency: current_state reflects inputs one edge later; next_state and tc have zero latency.

Test Plan (WIDTH=4, MODULUS=10, WRAP=1, RESET_VAL=0 unless noted):
- Reset and up-count: rst_n low, then en=1, x=1 for 12 cycles -> current_state 0,1,..,9,0,1,2; tc=1 only while current_state=9; wrap=1 in the single cycle where current_state=0 after the 9->0 transition.
- Down-count wrap: load=1, load_val=2; then en=1, x=0 for 4 cycles -> 2,1,0,9,8; tc=1 at 0; wrap pulse one cycle after the 0->9 edge; next_state always leads current_state by one cycle.
- Load priority and clamp:
  - load=1, load_val=13, en=1 -> current_state=9, no wrap.
  - load=1, load_val=5, en=0 -> current_state=5.
- Saturate mode (WRAP=0): up from 7 for 5 cycles -> 8,9,9,9,9, tc held 1, wrap never asserted; down from 1 -> 0,0, tc=1.
- Hold and direction flip: at 4, en=0 for 3 cycles -> stays 4, t=0; en=1 with x toggling every cycle starting x=1 -> 5,4,5,4.
- Async reset mid-count: at current_state=6, drop rst_n between edges -> current_state=0 immediately (RESET_VAL=3 build: 3); wrap cleared; counting resumes from the reset value on the first edge after release.
